uart_tx_cfg: RTL and testbench

//  Parametrised UART transmitter, successor to the fixed 8N1 transmitter.

---
 rtl/uart_tx_cfg.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with run-time character length (5-8), parity (none/even/odd) and 1/2 stop bits.
// Frame settings are latched on the valid/ready handshake; Tx is a registered output.
module uart_tx_cfg #(
  parameter int unsigned n       = 8,
  parameter bit          IDLE_LV = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] BR,
  input  logic [1:0]   char_len,
  input  logic         par_en,
  input  logic         par_odd,
  input  logic         stop2,
  input  logic         tx_valid,
  input  logic [7:0]   DATA_Tx,
  output logic         tx_ready,
  output logic         Tx,
  output logic         busy,
  output logic         eop
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e       state_q, state_d;
  logic [n:0]   baud_q, baud_d;
  logic [2:0]   bit_q, bit_d;
  logic [2:0]   last_q, last_d;
  logic [7:0]   data_q, data_d;
  logic         par_en_q, par_en_d;
  logic         par_q, par_d;
  logic [n-1:0] br_q, br_d;
  logic [n:0]   stop_len_q, stop_len_d;
  logic         tx_q, tx_d;
  logic         eop_q, eop_d;

  logic         accept;
  logic         bit_end;
  logic         stop_end;
  logic         no_stop;
  logic [n:0]   baud_inc;
  logic [7:0]   len_mask;

  assign accept   = tx_valid & (state_q == StIdle);
  assign baud_inc = baud_q + {{n{1'b0}}, 1'b1};
  assign bit_end  = (baud_q == {1'b0, br_q});
  assign stop_end = (baud_inc == stop_len_q);
  assign no_stop  = (stop_len_q == '0);
  assign len_mask = 8'hFF >> (2'd3 - char_len);

  // The final stop-bit cycle is spent in StIdle with eop high, so a transfer in
  // that cycle lets frames abut. StStop therefore covers all but one stop cycle.
  always_comb begin
    data_d     = data_q;
    br_d       = br_q;
    last_d     = last_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    stop_len_d = stop_len_q;
    if (accept) begin
      data_d     = DATA_Tx;
      br_d       = BR;
      last_d     = {1'b1, char_len};
      par_en_d   = par_en;
      par_d      = par_odd ^ (^(DATA_Tx & len_mask));
      stop_len_d = stop2 ? {BR, 1'b1} : {1'b0, BR};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      last_q     <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      br_q       <= '0;
      stop_len_q <= '0;
      tx_q       <= IDLE_LV;
      eop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      last_q     <= last_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      br_q       <= br_d;
      stop_len_q <= stop_len_d;
      tx_q       <= tx_d;
      eop_q      <= eop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          state_d = StStart;
          baud_d  = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_inc;
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == last_q) begin
            if (par_en_q) state_d = StParity;
            else          state_d = no_stop ? StIdle : StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_inc;
        end
      end
      StParity: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = no_stop ? StIdle : StStop;
        end else begin
          baud_d = baud_inc;
        end
      end
      StStop: begin
        if (stop_end) begin
          state_d = StIdle;
          baud_d  = '0;
        end else begin
          baud_d = baud_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_d = IDLE_LV;
    unique case (state_d)
      StIdle:   tx_d = IDLE_LV;
      StStart:  tx_d = ~IDLE_LV;
      StData:   tx_d = data_q[bit_d];
      StParity: tx_d = par_q;
      StStop:   tx_d = IDLE_LV;
      default:  tx_d = IDLE_LV;
    endcase
    eop_d    = (state_q != StIdle) && (state_d == StIdle);
    tx_ready = (state_q == StIdle);
    busy     = (state_q != StIdle);
  end

  assign Tx  = tx_q;
  assign eop = eop_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: fixed frame vectors, back-to-back and mid-frame reset sequences,
// then random frames checked against a bit-list reference model.
module tb_uart_tx_cfg;

  typedef struct packed {
    logic [7:0] br;
    logic [1:0] cl;
    logic       pe;
    logic       po;
    logic       s2;
    logic [7:0] data;
  } cfg_t;

  typedef struct {
    cfg_t        c;
    logic [11:0] lv;   // line level per bit slot, slot 0 in bit 0
    int          ns;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] BR;
  logic [1:0] char_len;
  logic       par_en, par_odd, stop2, tx_valid;
  logic [7:0] DATA_Tx;
  logic       tx_ready, Tx, busy, eop;

  int n_tests   = 0;
  int n_fail    = 0;
  int eop_total = 0;

  uart_tx_cfg #(.n(8), .IDLE_LV(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .BR       (BR),
    .char_len (char_len),
    .par_en   (par_en),
    .par_odd  (par_odd),
    .stop2    (stop2),
    .tx_valid (tx_valid),
    .DATA_Tx  (DATA_Tx),
    .tx_ready (tx_ready),
    .Tx       (Tx),
    .busy     (busy),
    .eop      (eop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (eop === 1'b1) eop_total++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: list the bit slots of a frame, then each slot lasts BR+1 clocks.
  function automatic void model(input cfg_t c, output logic [11:0] lv, output int ns);
    int len  = int'(c.cl) + 5;
    int ones = 0;
    lv = '1;
    lv[0] = 1'b0;
    ns = 1;
    for (int i = 0; i < len; i++) begin
      lv[4'(ns)] = c.data[3'(i)];
      ones += int'(c.data[3'(i)]);
      ns++;
    end
    if (c.pe) begin
      lv[4'(ns)] = ((ones % 2) == 1) ^ c.po;
      ns++;
    end
    lv[4'(ns)] = 1'b1;
    ns++;
    if (c.s2) begin
      lv[4'(ns)] = 1'b1;
      ns++;
    end
  endfunction

  function automatic vec_t mk(input logic [7:0] br, input logic [1:0] cl, input logic pe,
                              input logic po, input logic s2, input logic [7:0] d,
                              input logic [11:0] lv, input int ns);
    vec_t v;
    v.c.br = br; v.c.cl = cl; v.c.pe = pe; v.c.po = po; v.c.s2 = s2; v.c.data = d;
    v.lv = lv;
    v.ns = ns;
    return v;
  endfunction

  // Called at a negedge with the DUT ready; returns at the negedge of the eop cycle.
  task automatic send_frame(input cfg_t c, input logic [11:0] lv, input int ns,
                            input bit hold, input string nm);
    int   bp      = int'(c.br) + 1;
    int   nclk    = ns * bp;
    int   wave_err = 0;
    int   first   = -1;
    int   eop_err = 0;
    int   rb_err  = 0;
    logic exp_lv;
    chk({nm, " ready_at_start"}, {31'd0, tx_ready}, 32'd1);
    BR = c.br; char_len = c.cl; par_en = c.pe; par_odd = c.po; stop2 = c.s2;
    DATA_Tx = c.data; tx_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      // Frame must be unaffected by inputs changing after the handshake.
      tx_valid = 1'b0;
      BR = 8'($urandom_range(0, 7)); char_len = 2'($urandom); par_en = 1'($urandom);
      par_odd = 1'($urandom); stop2 = 1'($urandom); DATA_Tx = 8'($urandom);
    end
    for (int k = 0; k < nclk; k++) begin
      @(negedge clk);
      exp_lv = lv[4'(k / bp)];
      if (Tx !== exp_lv) begin
        wave_err++;
        if (first < 0) first = k;
      end
      if (eop !== (k == nclk - 1)) eop_err++;
      if (busy !== (k != nclk - 1) || tx_ready !== (k == nclk - 1)) rb_err++;
    end
    if (first >= 0) $display("  %s: first Tx difference at clk %0d", nm, first);
    chk({nm, " tx_wave_errors"}, 32'(wave_err), 32'd0);
    chk({nm, " eop_errors"}, 32'(eop_err), 32'd0);
    chk({nm, " busy_ready_errors"}, 32'(rb_err), 32'd0);
  endtask

  initial begin
    vec_t        vecs[5];
    cfg_t        c;
    logic [11:0] lv;
    int          ns;
    int          e0;
    int          tx_err;

    vecs[0] = mk(8'd3, 2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 12'h34A, 10); // 8N1 A5, 40 clks
    vecs[1] = mk(8'd0, 2'b00, 1'b1, 1'b0, 1'b0, 8'hFF, 12'h0FE, 8);  // 5E1 FF, 8 clks
    vecs[2] = mk(8'd1, 2'b10, 1'b1, 1'b1, 1'b1, 8'h41, 12'h782, 11); // 7O2 41, 22 clks
    vecs[3] = mk(8'd0, 2'b01, 1'b0, 1'b0, 1'b0, 8'h2A, 12'h0D4, 8);  // 6N1 2A
    vecs[4] = mk(8'd2, 2'b00, 1'b1, 1'b0, 1'b0, 8'h03, 12'h086, 8);  // 5E1 03, 24 clks

    rst = 1'b1; tx_valid = 1'b0; BR = '0; char_len = '0; par_en = 1'b0; par_odd = 1'b0;
    stop2 = 1'b0; DATA_Tx = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset Tx", {31'd0, Tx}, 32'd1);
    chk("reset tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset eop", {31'd0, eop}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].c, vecs[i].lv, vecs[i].ns, 1'b0, $sformatf("vec%0d", i));
      repeat (2) @(negedge clk);
    end

    // tx_valid held high for three 8N1 characters at BR=2: frames must abut.
    #1 e0 = eop_total;
    for (int i = 0; i < 3; i++) begin
      c = '{br: 8'd2, cl: 2'b11, pe: 1'b0, po: 1'b0, s2: 1'b0, data: 8'(8'h55 + 8'(i * 37))};
      model(c, lv, ns);
      send_frame(c, lv, ns, 1'b1, $sformatf("b2b%0d", i));
    end
    tx_valid = 1'b0;
    @(negedge clk);
    #1 chk("b2b eop_count", 32'(eop_total - e0), 32'd3);
    chk("b2b idle_after", {31'd0, tx_ready}, 32'd1);

    // Reset mid-frame: line back to idle immediately, no eop afterwards.
    @(negedge clk);
    BR = 8'd2; char_len = 2'b11; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
    DATA_Tx = 8'h00; tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (7) @(negedge clk);
    #1 e0 = eop_total;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midreset Tx", {31'd0, Tx}, 32'd1);
    chk("midreset tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("midreset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tx_err = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (Tx !== 1'b1 || busy !== 1'b0) tx_err++;
    end
    #1 chk("midreset eop_count", 32'(eop_total - e0), 32'd0);
    chk("midreset line_idle_errors", 32'(tx_err), 32'd0);

    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      c.br = 8'($urandom_range(0, 3));
      c.cl = 2'($urandom);
      c.pe = 1'($urandom);
      c.po = 1'($urandom);
      c.s2 = 1'($urandom);
      c.data = 8'($urandom);
      model(c, lv, ns);
      send_frame(c, lv, ns, 1'b0, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
